// File: rtl/debug_unit_transmit.sv
// Streams PC, GPRs and a data-memory window to uart_tx, one byte per tx_start/tx_done handshake, MSB first.
// Latency: start -> first o_tx_start 1 cycle; each word boundary adds 3 cycles (NEXT, FETCH, CAPTURE).
// Backpressure: holds o_tx_data until i_tx_done, no timeout; DU_TX_CYCLE_COUNT_EN appends a cycle-count word.
module debug_unit_transmit #(
    parameter int NB_DATA     = 32,
    parameter int NB_BYTE     = 8,
    parameter int NB_REGISTER = 5,
    parameter int NB_MEM_ADDR = 5,
    parameter int N_MEM_WORDS = 16,
    parameter int NB_STATE    = 3
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_send_start,
    input  logic [NB_DATA-1:0]     i_pc,
`ifdef DU_TX_CYCLE_COUNT_EN
    input  logic [NB_DATA-1:0]     i_cycle_count,
`endif
    output logic [NB_REGISTER-1:0] o_register_addr,
    input  logic [NB_DATA-1:0]     i_register_data,
    output logic [NB_MEM_ADDR-1:0] o_memory_addr,
    input  logic [NB_DATA-1:0]     i_memory_data,
    output logic [NB_BYTE-1:0]     o_tx_data,
    output logic                   o_tx_start,
    input  logic                   i_tx_done,
    output logic                   o_busy,
    output logic                   o_send_done,
    output logic [NB_STATE-1:0]    o_state
);

    localparam int N_REGS = 2**NB_REGISTER;
`ifdef DU_TX_CYCLE_COUNT_EN
    localparam int N_EXTRA = 1;
`else
    localparam int N_EXTRA = 0;
`endif
    localparam int N_WORDS        = 1 + N_REGS + N_MEM_WORDS + N_EXTRA;
    localparam int NB_IDX         = $clog2(N_WORDS) + 1;
    localparam int BYTES_PER_WORD = NB_DATA / NB_BYTE;
    localparam int NB_BCNT        = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    // Word index: 0 = PC, then GPRs, then memory words, then optional cycle count.
    localparam logic [NB_IDX-1:0]  IDX_REG0  = NB_IDX'(1);
    localparam logic [NB_IDX-1:0]  IDX_MEM0  = NB_IDX'(1 + N_REGS);
    localparam logic [NB_IDX-1:0]  IDX_MEME  = NB_IDX'(1 + N_REGS + N_MEM_WORDS);
    localparam logic [NB_IDX-1:0]  IDX_LAST  = NB_IDX'(N_WORDS - 1);
    localparam logic [NB_BCNT-1:0] BCNT_LAST = NB_BCNT'(BYTES_PER_WORD - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SEND    = 3'd3,
        ST_WAIT_TX = 3'd4,
        ST_NEXT    = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    state_t             state;
    logic [NB_DATA-1:0] shift_dat;
    logic [NB_IDX-1:0]  idx;
    logic [NB_IDX-1:0]  idx_nxt;
    logic [NB_BCNT-1:0] byte_cnt;
    logic [NB_DATA-1:0] capture_dat;
`ifdef DU_TX_CYCLE_COUNT_EN
    logic [NB_DATA-1:0] cycle_q;
`endif

    assign o_state = NB_STATE'(state);
    assign idx_nxt = idx + NB_IDX'(1);

    always_comb begin
        capture_dat = i_register_data;
        if (idx >= IDX_MEM0) begin
            capture_dat = i_memory_data;
        end
`ifdef DU_TX_CYCLE_COUNT_EN
        if (idx == IDX_LAST) begin
            capture_dat = cycle_q;
        end
`endif
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state           <= ST_IDLE;
            shift_dat       <= '0;
            idx             <= '0;
            byte_cnt        <= '0;
            o_register_addr <= '0;
            o_memory_addr   <= '0;
            o_tx_data       <= '0;
            o_tx_start      <= 1'b0;
            o_busy          <= 1'b0;
            o_send_done     <= 1'b0;
`ifdef DU_TX_CYCLE_COUNT_EN
            cycle_q         <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_send_start) begin
                        shift_dat  <= i_pc;
                        o_tx_data  <= i_pc[NB_DATA-1 -: NB_BYTE];
                        o_tx_start <= 1'b1;
                        o_busy     <= 1'b1;
                        idx        <= '0;
                        byte_cnt   <= '0;
`ifdef DU_TX_CYCLE_COUNT_EN
                        cycle_q    <= i_cycle_count;
`endif
                        state      <= ST_SEND;
                    end
                end
                ST_FETCH: begin
                    state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    shift_dat  <= capture_dat;
                    o_tx_data  <= capture_dat[NB_DATA-1 -: NB_BYTE];
                    o_tx_start <= 1'b1;
                    state      <= ST_SEND;
                end
                ST_SEND: begin
                    o_tx_start <= 1'b0;
                    state      <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    if (i_tx_done) begin
                        shift_dat <= shift_dat << NB_BYTE;
                        if (byte_cnt == BCNT_LAST) begin
                            byte_cnt <= '0;
                            state    <= ST_NEXT;
                        end else begin
                            byte_cnt   <= byte_cnt + NB_BCNT'(1);
                            // Next byte is the one below the current MSB, before the shift lands.
                            o_tx_data  <= shift_dat[NB_DATA-NB_BYTE-1 -: NB_BYTE];
                            o_tx_start <= 1'b1;
                            state      <= ST_SEND;
                        end
                    end
                end
                ST_NEXT: begin
                    if (idx == IDX_LAST) begin
                        o_send_done <= 1'b1;
                        o_busy      <= 1'b0;
                        state       <= ST_DONE;
                    end else begin
                        idx <= idx_nxt;
                        if (idx_nxt < IDX_MEM0) begin
                            o_register_addr <= NB_REGISTER'(idx_nxt - IDX_REG0);
                        end else if (idx_nxt < IDX_MEME) begin
                            o_memory_addr <= NB_MEM_ADDR'(idx_nxt - IDX_MEM0);
                        end
                        state <= ST_FETCH;
                    end
                end
                ST_DONE: begin
                    o_send_done <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: begin
                    o_tx_start  <= 1'b0;
                    o_send_done <= 1'b0;
                    o_busy      <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_unit_transmit.sv
// Scoreboard bench for debug_unit_transmit: a UART model acks each byte 3 cycles after o_tx_start,
// expected bytes are queued when a dump is launched and popped as the DUT emits them.
module tb_debug_unit_transmit;

`ifdef DU_TX_CYCLE_COUNT_EN
    localparam int EXP_BYTES = 200;
`else
    localparam int EXP_BYTES = 196;
`endif
    localparam int BUDGET = 4000;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_send_start;
    logic [31:0] i_pc;
`ifdef DU_TX_CYCLE_COUNT_EN
    logic [31:0] i_cycle_count;
`endif
    logic [4:0]  o_register_addr;
    logic [31:0] i_register_data;
    logic [4:0]  o_memory_addr;
    logic [31:0] i_memory_data;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        i_tx_done;
    logic        o_busy;
    logic        o_send_done;
    logic [2:0]  o_state;

    debug_unit_transmit dut (
        .i_clock         (i_clock),
        .i_reset         (i_reset),
        .i_send_start    (i_send_start),
        .i_pc            (i_pc),
`ifdef DU_TX_CYCLE_COUNT_EN
        .i_cycle_count   (i_cycle_count),
`endif
        .o_register_addr (o_register_addr),
        .i_register_data (i_register_data),
        .o_memory_addr   (o_memory_addr),
        .i_memory_data   (i_memory_data),
        .o_tx_data       (o_tx_data),
        .o_tx_start      (o_tx_start),
        .i_tx_done       (i_tx_done),
        .o_busy          (o_busy),
        .o_send_done     (o_send_done),
        .o_state         (o_state)
    );

    always #5 i_clock = ~i_clock;

    int cyc = 0;
    always @(posedge i_clock) cyc <= cyc + 1;

    logic [31:0] regs [0:31];
    logic [31:0] mem  [0:31];
    always @(posedge i_clock) begin
        i_register_data <= regs[o_register_addr];
        i_memory_data   <= mem[o_memory_addr];
    end

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_log [0:255];
    int         tx_cyc [0:255];
    int         rx_cnt = 0;
    int         done_cnt = 0;
    int         start_cyc = 0;
    bit         stray_mode = 0;

    // UART model and output monitor; runs forked from the main initial block.
    task automatic monitor_loop();
        bit         waiting = 0;
        int         ack_cnt = 0;
        logic [7:0] held = '0;
        logic [7:0] e;
        bit         prev_start = 0;
        bit         prev_done = 0;
        forever begin
            @(negedge i_clock);
            if (!i_reset) begin
                waiting = 0; ack_cnt = 0; i_tx_done = 1'b0;
                prev_start = 0; prev_done = 0;
                continue;
            end
            i_tx_done = 1'b0;
            if (waiting) begin
                checks++;
                if (o_tx_data !== held) begin
                    failures++;
                    $display("FAIL tx_data_hold got=%h exp=%h", o_tx_data, held);
                end
                ack_cnt--;
                if (ack_cnt == 0) begin
                    i_tx_done = 1'b1;
                    waiting = 0;
                end
            end
            if (o_tx_start === 1'b1) begin
                checks++;
                if (prev_start) begin
                    failures++;
                    $display("FAIL tx_start_width got=2+ cycles exp=1 cycle");
                end
                if (rx_cnt < 256) begin
                    rx_log[rx_cnt] = o_tx_data;
                    tx_cyc[rx_cnt] = cyc;
                end
                rx_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_byte got=%h exp=none", o_tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (o_tx_data !== e) begin
                        failures++;
                        $display("FAIL stream_byte%0d got=%h exp=%h", rx_cnt - 1, o_tx_data, e);
                    end
                end
                checks++;
                if (o_busy !== 1'b1) begin
                    failures++;
                    $display("FAIL busy_during_dump got=%b exp=1", o_busy);
                end
                held = o_tx_data;
                waiting = 1;
                ack_cnt = 3;
                if (stray_mode) i_tx_done = 1'b1;
            end
            if (stray_mode && (o_state == 3'd5 || o_state == 3'd1)) i_tx_done = 1'b1;
            if (o_send_done === 1'b1) begin
                done_cnt++;
                checks++;
                if (prev_done) begin
                    failures++;
                    $display("FAIL send_done_width got=2+ cycles exp=1 cycle");
                end
            end
            prev_start = (o_tx_start === 1'b1);
            prev_done  = (o_send_done === 1'b1);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) exp_q.push_back(w[31-8*b -: 8]);
    endtask

    task automatic push_stream(input logic [31:0] pc);
        push_word(pc);
        for (int n = 0; n < 32; n++) push_word(32'h01010101 * n);
        for (int k = 0; k < 16; k++) push_word(32'hC0DE0000 + k);
`ifdef DU_TX_CYCLE_COUNT_EN
        push_word(i_cycle_count);
`endif
    endtask

    task automatic run_dump(input logic [31:0] pc, input bit extra_starts);
        bit finished = 0;
        rx_cnt = 0;
        done_cnt = 0;
        push_stream(pc);
        @(negedge i_clock);
        i_pc = pc;
        i_send_start = 1'b1;
        start_cyc = cyc;
        @(negedge i_clock);
        i_send_start = 1'b0;
        i_pc = 32'hFFFF_FFFF;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge i_clock);
            i_send_start = (extra_starts && (i % 97 == 50) && done_cnt == 0);
            if (done_cnt > 0) begin
                finished = 1;
                break;
            end
        end
        i_send_start = 1'b0;
        repeat (4) @(negedge i_clock);
        checks++;
        if (!finished) begin
            failures++;
            $display("FAIL dump_timeout got=%0d bytes exp=%0d", rx_cnt, EXP_BYTES);
        end
        checks++;
        if (rx_cnt != EXP_BYTES) begin
            failures++;
            $display("FAIL byte_count got=%0d exp=%0d", rx_cnt, EXP_BYTES);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size());
        end
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL send_done_count got=%0d exp=1", done_cnt);
        end
        checks++;
        if (o_busy !== 1'b0 || o_state !== 3'd0) begin
            failures++;
            $display("FAIL idle_after_dump got=busy%b/st%0d exp=busy0/st0", o_busy, o_state);
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        i_send_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clock);
            checks++;
            if (o_tx_start !== 1'b0 || o_state !== 3'd0 || o_busy !== 1'b0 || o_send_done !== 1'b0) begin
                failures++;
                $display("FAIL reset_ctrl got=start%b st%0d busy%b done%b exp=0", o_tx_start, o_state, o_busy, o_send_done);
            end
            checks++;
            if (o_tx_data !== 8'h00 || o_register_addr !== 5'd0 || o_memory_addr !== 5'd0) begin
                failures++;
                $display("FAIL reset_data got=%h/%h/%h exp=0", o_tx_data, o_register_addr, o_memory_addr);
            end
        end
        i_send_start = 1'b0;
        @(negedge i_clock);
        i_reset = 1'b1;
        repeat (3) @(negedge i_clock);
        checks++;
        if (o_state !== 3'd0 || rx_cnt != 0) begin
            failures++;
            $display("FAIL reset_release got=st%0d bytes%0d exp=st0 bytes0", o_state, rx_cnt);
        end
    endtask

    task automatic test_first_bytes();
        logic [31:0] pcw;
        pcw = 32'h00400010;
        run_dump(pcw, 0);
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (rx_log[b] !== pcw[31-8*b -: 8]) begin
                failures++;
                $display("FAIL pc_byte%0d got=%h exp=%h", b, rx_log[b], pcw[31-8*b -: 8]);
            end
        end
        checks++;
        if (tx_cyc[0] - start_cyc != 1) begin
            failures++;
            $display("FAIL start_latency got=%0d exp=1", tx_cyc[0] - start_cyc);
        end
        checks++;
        if (tx_cyc[1] - tx_cyc[0] != 4) begin
            failures++;
            $display("FAIL intra_word_gap got=%0d exp=4", tx_cyc[1] - tx_cyc[0]);
        end
        checks++;
        if (tx_cyc[4] - tx_cyc[3] != 7) begin
            failures++;
            $display("FAIL word_boundary_gap got=%0d exp=7", tx_cyc[4] - tx_cyc[3]);
        end
    endtask

    task automatic test_full_stream();
        logic [31:0] m15;
        m15 = 32'hC0DE000F;
        run_dump(32'h12345678, 0);
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (rx_log[128 + b] !== 8'h1F) begin
                failures++;
                $display("FAIL r31_byte%0d got=%h exp=1f", b, rx_log[128 + b]);
            end
            checks++;
            if (rx_log[192 + b] !== m15[31-8*b -: 8]) begin
                failures++;
                $display("FAIL mem15_byte%0d got=%h exp=%h", b, rx_log[192 + b], m15[31-8*b -: 8]);
            end
        end
    endtask

    task automatic test_ignored_inputs();
        stray_mode = 1;
        run_dump(32'hCAFEF00D, 1);
        stray_mode = 0;
    endtask

    task automatic test_reset_mid_dump();
        bit reached = 0;
        rx_cnt = 0;
        done_cnt = 0;
        push_stream(32'h0BADBEEF);
        @(negedge i_clock);
        i_pc = 32'h0BADBEEF;
        i_send_start = 1'b1;
        @(negedge i_clock);
        i_send_start = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge i_clock);
            if (rx_cnt >= 50) begin
                reached = 1;
                break;
            end
        end
        checks++;
        if (!reached) begin
            failures++;
            $display("FAIL reach_byte50 got=%0d exp=50", rx_cnt);
        end
        #2 i_reset = 1'b0;
        #1;
        checks++;
        if (o_tx_start !== 1'b0 || o_state !== 3'd0 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got=start%b st%0d busy%b exp=0", o_tx_start, o_state, o_busy);
        end
        repeat (4) @(negedge i_clock);
        checks++;
        if (done_cnt != 0) begin
            failures++;
            $display("FAIL mid_reset_done got=%0d exp=0", done_cnt);
        end
        exp_q.delete();
        i_reset = 1'b1;
        repeat (2) @(negedge i_clock);
        run_dump(32'h00400010, 0);
    endtask

`ifdef DU_TX_CYCLE_COUNT_EN
    task automatic test_cycle_count();
        logic [31:0] cc;
        cc = 32'h0000012C;
        i_cycle_count = cc;
        run_dump(32'h00400010, 0);
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (rx_log[196 + b] !== cc[31-8*b -: 8]) begin
                failures++;
                $display("FAIL cycle_byte%0d got=%h exp=%h", b, rx_log[196 + b], cc[31-8*b -: 8]);
            end
        end
    endtask
`endif

    initial begin
        i_reset = 1'b0;
        i_send_start = 1'b1;
        i_pc = 32'h0;
        i_tx_done = 1'b0;
`ifdef DU_TX_CYCLE_COUNT_EN
        i_cycle_count = 32'h0;
`endif
        for (int n = 0; n < 32; n++) begin
            regs[n] = 32'h01010101 * n;
            mem[n]  = (n < 16) ? (32'hC0DE0000 + n) : 32'hDEADBEEF;
        end
        fork
            monitor_loop();
        join_none
        test_reset();
        test_first_bytes();
        test_full_stream();
        test_ignored_inputs();
        test_reset_mid_dump();
`ifdef DU_TX_CYCLE_COUNT_EN
        test_cycle_count();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
